// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = XLEN;
  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic                div_mode,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // Shifted partial remainder can reach 33 bits before the trial subtract.
    rem_sh = acc[2*XLEN-1:XLEN-1];
    fits   = rem_sh >= {1'b0, operand};
    diff   = rem_sh[XLEN-1:0] - operand;
    if (div_mode) begin
      if (fits) acc_next = {diff, acc[XLEN-2:0], 1'b1};
      else      acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_con_Start,
  input  logic [1:0]      i_con_Op,
  input  logic [XLEN-1:0] i_data_A,
  input  logic [XLEN-1:0] i_data_B,
  input  logic            i_con_Flush,
  input  logic            i_con_WrHi,
  input  logic            i_con_WrLo,
  input  logic [XLEN-1:0] i_data_Wr,
  output logic            o_con_Busy,
  output logic            o_con_Done,
  output logic [XLEN-1:0] o_data_Hi,
  output logic [XLEN-1:0] o_data_Lo
);

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  op_t                op_q;
  logic [2*XLEN-1:0]  acc_q, acc_step;
  logic [XLEN-1:0]    operand_q, orig_a_q;
  logic               neg_q, neg_rem_q, div_zero_q;
  logic [XLEN-1:0]    hi_q, lo_q;
  logic               busy_q, done_q;

  logic               load, step_en, commit, mt_en, busy_nxt, done_nxt;

  op_t                op_in;
  logic               sgn, a_neg, b_neg;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    fix_hi, fix_lo;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (i_con_Start && !i_con_Flush) state_nxt = ST_CALC;
      ST_CALC: begin
        if (i_con_Flush)                        state_nxt = ST_IDLE;
        else if (cnt_q == CNT_W'(ITER - 1))     state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    load     = 1'b0;
    step_en  = 1'b0;
    commit   = 1'b0;
    mt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mt_en = 1'b1;
        load  = i_con_Start && !i_con_Flush;
      end
      ST_CALC: step_en = !i_con_Flush;
      ST_FIX:  commit  = !i_con_Flush;
      default: ;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = commit;
  end

  // Operand magnitudes and result signs captured at launch
  always_comb begin
    op_in = op_t'(i_con_Op);
    sgn   = op_is_signed(op_in);
    a_neg = sgn && i_data_A[XLEN-1];
    b_neg = sgn && i_data_B[XLEN-1];
    mag_a = a_neg ? XLEN'(-i_data_A) : i_data_A;
    mag_b = b_neg ? XLEN'(-i_data_B) : i_data_B;
  end

  muldiv_step u_step (
    .div_mode (op_is_div(op_q)),
    .acc      (acc_q),
    .operand  (operand_q),
    .acc_next (acc_step)
  );

  // Sign correction and divide-by-zero override applied at FIX
  always_comb begin
    prod = neg_q ? (2*XLEN)'(-acc_q) : acc_q;
    if (!op_is_div(op_q)) begin
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
    end else if (div_zero_q) begin
      fix_hi = orig_a_q;
      fix_lo = '1;
    end else begin
      fix_hi = neg_rem_q ? XLEN'(-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
      fix_lo = neg_q     ? XLEN'(-acc_q[XLEN-1:0])      : acc_q[XLEN-1:0];
    end
  end

  // Datapath and HI/LO registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      acc_q      <= '0;
      operand_q  <= '0;
      orig_a_q   <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (load) begin
        op_q       <= op_in;
        cnt_q      <= '0;
        orig_a_q   <= i_data_A;
        neg_q      <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        div_zero_q <= (i_data_B == '0);
        if (op_is_div(op_in)) begin
          acc_q     <= {{XLEN{1'b0}}, mag_a};
          operand_q <= mag_b;
        end else begin
          acc_q     <= {{XLEN{1'b0}}, mag_b};
          operand_q <= mag_a;
        end
      end else if (step_en) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (mt_en && i_con_WrHi) hi_q <= i_data_Wr;
      if (mt_en && i_con_WrLo) lo_q <= i_data_Wr;
      if (commit) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign o_con_Busy = busy_q;
  assign o_con_Done = done_q;
  assign o_data_Hi  = hi_q;
  assign o_data_Lo  = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: golden results from native SV arithmetic.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, wr_hi, wr_lo;
  logic [1:0]  op_in;
  logic [31:0] data_a, data_b, wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  muldiv_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_con_Start (start),
    .i_con_Op    (op_in),
    .i_data_A    (data_a),
    .i_data_B    (data_b),
    .i_con_Flush (flush),
    .i_con_WrHi  (wr_hi),
    .i_con_WrLo  (wr_lo),
    .i_data_Wr   (wr_data),
    .o_con_Busy  (busy),
    .o_con_Done  (done),
    .o_data_Hi   (hi),
    .o_data_Lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, m;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      2'd0: r = 64'(sa * sb);
      2'd1: r = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFFFFFF};
        end else begin
          if (op == 2'd2) begin
            q = 32'(sa / sb);
            m = 32'(sa % sb);
          end else begin
            q = a / b;
            m = a % b;
          end
          r = {m, q};
        end
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) check("busy_done_excl", 64'(busy & done), 64'd0);

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject);
    int n, busy_cycles;
    @(negedge clk);
    start = 1'b1; op_in = op; data_a = a; data_b = b;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_cycles = 0;
    while (!done && n < 100) begin
      if (busy) busy_cycles++;
      if (inject && n == 5) begin
        start = 1'b1; op_in = 2'd1; data_a = 32'h55; data_b = 32'h3;
        wr_hi = 1'b1; wr_data = 32'hDEAD;
      end else begin
        start = 1'b0; wr_hi = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; wr_hi = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("busy_cycles", 64'(busy_cycles), 64'd33);
    if (exp_q.size() == 0) check("sb_nonempty", 64'd0, 64'd1);
    else check("result", {hi, lo}, exp_q.pop_front());
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] prior;
    bit done_seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op_in = 2'd0; data_a = '0; data_b = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    do_op(2'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
    do_op(2'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    do_op(2'd3, 32'd100, 32'd7, 1'b0);
    do_op(2'd3, 32'h64, 32'd0, 1'b0);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    do_op(2'd2, 32'hFFFFFF9C, 32'd0, 1'b0);
    do_op(2'd0, 32'h80000000, 32'h80000000, 1'b0);
    for (int i = 0; i < 6; i++)
      do_op(2'(i % 4), $urandom, (i == 5) ? 32'(-3) : $urandom_range(1, 32'h7FFFFFFF), 1'b0);

    // Flush mid-operation: no Done, HI/LO untouched
    prior = {hi, lo};
    @(negedge clk);
    start = 1'b1; op_in = 2'd1; data_a = 32'd3; data_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hilo", {hi, lo}, prior);
    do_op(2'd1, 32'd3, 32'd5, 1'b0);

    // Start and MTHI during Busy are ignored
    do_op(2'd0, 32'd1234567, 32'hFFFFF000, 1'b1);
    prior = {hi, lo};
    wr_lo = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo", {hi, lo}, {prior[63:32], 32'h1234});

    // Reset mid-DIV
    @(negedge clk);
    start = 1'b1; op_in = 2'd2; data_a = 32'd1000; data_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_state", 64'(dut.state_q), 64'(ST_IDLE));
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
